data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//   Parametrised, byte-addressable data memory with sub-word access for the MIPS MEM stage.
//   Supports lb/lbu/lh/lhu/lw/sb/sh/sw with sign or zero extension.
//   Uses a valid/ready request channel and a one-cycle response pulse.
//   Programmable wait states model slow memory.
//   Detects misaligned, out-of-range and illegal-size accesses; faulting accesses never touch memory.
// PARAMETERS
//   ADDR_WIDTH   10  byte-address bits actually decoded; memory holds 2**ADDR_WIDTH bytes
//   WAIT_STATES  1   extra cycles between request accept and memory access (0..15)
//   BIG_ENDIAN   1   1: byte at addr is MSB of the word/half; 0: byte at addr is LSB
// PORTS
//   clk          in   1   clock; all state updates on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req_valid    in   1   request present
//   req_ready    out  1   block can accept a request this cycle
//   req_write    in   1   1 store, 0 load
//   req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned in   1   loads only: 1 zero-extend, 0 sign-extend
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data, right-justified (byte in [7:0], half in [15:0])
//   rsp_valid    out  1   one-cycle pulse: request completed
//   rsp_rdata    out  32  load result, extended to 32 bits; 0 for stores and faults
//   rsp_error    out  1   qualified by rsp_valid; 1 means the access was faulted
// BEHAVIOUR
//   Reset (rst_n low, async)
//     - state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0.
//     - Memory array is not cleared.
//     - A store not yet committed when reset asserts is discarded.
//   FSM states: IDLE, ACCESS, RESP.
//   IDLE
//     - req_ready=1.
//     - On req_valid at an edge: latch write, size, unsigned, addr and wdata.
//     - Load counter with WAIT_STATES and go to ACCESS.
//     - Request inputs are ignored outside IDLE.
//   ACCESS
//     - req_ready=0.
//     - counter!=0: decrement and stay.
//     - counter==0: at this edge perform the access (store commits or load data is captured), then go to RESP.
//   RESP
//     - rsp_valid=1 and the outputs are valid for exactly this cycle.
//     - Next edge returns to IDLE.
//     - rsp_rdata and rsp_error hold their values until the next response.
//   Latency
//     - Accept at edge E0; rsp_valid is high in the cycle following edge E0+WAIT_STATES+1.
//     - req_ready is high again in the cycle after that.
//     - Throughput is 1 request per WAIT_STATES+3 cycles.
//   Faults, checked on the latched request
//     - size==11.
//     - half with addr[0]!=0; word with addr[1:0]!=0.
//     - addr >= 2**ADDR_WIDTH, i.e. any bit of addr[31:ADDR_WIDTH] set.
//     - A fault follows the same timing path.
//     - No memory write is performed; rsp_error=1 and rsp_rdata=0.
//   Byte lanes (BIG_ENDIAN=1)
//     - word = {m[a],m[a+1],m[a+2],m[a+3]}; half = {m[a],m[a+1]}.
//     - BIG_ENDIAN=0 reverses the byte order.
//     - Stores write only the bytes addressed by size; other bytes are unchanged.
//   Extension
//     - Byte loads extend from bit 7 and half loads from bit 15 when req_unsigned=0; otherwise zero-extend.
//     - Word loads ignore req_unsigned.
//   No read-during-write hazard: one access per transaction, and each transaction sees all earlier commits.
// TESTING
//   1. sw 0x11223344 @0x10, then lw @0x10 -> rsp_rdata=0x11223344 and rsp_error=0 on both responses.
//   2. After test 1: lb @0x10 -> 0x00000011; sb 0xF0 @0x11 then lh @0x10 -> 0x000011F0.
//   3. Sign/zero extension after test 2: lbu @0x11 -> 0x000000F0; lb @0x11 -> 0xFFFFFFF0;
//      lhu @0x10 -> 0x000011F0; lw @0x10 -> 0x11F03344.
//   4. Faults: lw @0x12 (misaligned), sh @0x401 (misaligned), sw @0x400 with ADDR_WIDTH=10 (out of range),
//      size=11 -> rsp_error=1, rsp_rdata=0; a later lw @0x400-aligned in-range word still holds its old value.
//   5. Timing: with WAIT_STATES=0 and 3, hold req_valid high continuously -> rsp_valid exactly WAIT_STATES+1
//      edges after each accept; req_ready low for WAIT_STATES+2 cycles per request.
//   6. Reset: pulse rst_n low mid-ACCESS of sw 0xDEADBEEF @0x20, asynchronous to clk
//      -> outputs reach reset values immediately; a later lw @0x20 returns the old contents.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//   Byte-addressable data memory for the MIPS MEM stage. It handles
//   lb/lbu/lh/lhu/lw/sb/sh/sw with sign or zero extension, a valid/ready
//   request channel, a one-cycle response pulse and programmable wait states.
//   Misaligned, out-of-range and illegal-size accesses are reported through
//   rsp_error and never modify the memory.
//
// Ports
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   req_valid     in   1   request present
//   req_ready     out  1   request accepted at the next edge when high
//   req_write     in   1   1 store, 0 load
//   req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in   1   loads: 1 zero-extend, 0 sign-extend
//   req_addr      in   32  byte address
//   req_wdata     in   32  right-justified store data
//   rsp_valid     out  1   one-cycle completion pulse
//   rsp_rdata     out  32  extended load data; 0 for stores and faults
//   rsp_error     out  1   access faulted (qualified by rsp_valid)
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;

  // Latched request; data only, so no reset is needed.
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [7:0]  r_mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_fault;
  logic                  w_access;
  logic                  w_commit;
  logic [3:0]            w_be;
  logic [7:0]            w_wbyte [4];
  logic [7:0]            w_rbyte [4];
  logic [31:0]           w_load_raw;

  // Extend a right-justified load value according to size and signedness.
  function automatic logic [31:0] f_extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        uns);
    case (size)
      2'b00:   return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign w_base = r_addr[ADDR_WIDTH-1:0];

  assign w_fault = (r_size == 2'b11)
                || (r_size == 2'b01 && r_addr[0])
                || (r_size == 2'b10 && r_addr[1:0] != 2'b00)
                || (|r_addr[31:ADDR_WIDTH]);

  assign w_access = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_commit = w_access && r_write && !w_fault;

  // Lane k is the byte at address base+k.
  always_comb begin
    w_be = 4'b0000;
    for (int k = 0; k < 4; k++) w_wbyte[k] = 8'h00;
    case (r_size)
      2'b00: begin
        w_be       = 4'b0001;
        w_wbyte[0] = r_wdata[7:0];
      end
      2'b01: begin
        w_be = 4'b0011;
        if (BIG_ENDIAN != 0) begin
          w_wbyte[0] = r_wdata[15:8];
          w_wbyte[1] = r_wdata[7:0];
        end else begin
          w_wbyte[0] = r_wdata[7:0];
          w_wbyte[1] = r_wdata[15:8];
        end
      end
      2'b10: begin
        w_be = 4'b1111;
        for (int k = 0; k < 4; k++)
          w_wbyte[k] = (BIG_ENDIAN != 0) ? r_wdata[8*(3-k) +: 8] : r_wdata[8*k +: 8];
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 4; k++) w_rbyte[k] = r_mem[w_base + ADDR_WIDTH'(k)];
    case (r_size)
      2'b00: w_load_raw = {24'b0, w_rbyte[0]};
      2'b01: w_load_raw = (BIG_ENDIAN != 0) ? {16'b0, w_rbyte[0], w_rbyte[1]}
                                            : {16'b0, w_rbyte[1], w_rbyte[0]};
      default: w_load_raw = (BIG_ENDIAN != 0)
                            ? {w_rbyte[0], w_rbyte[1], w_rbyte[2], w_rbyte[3]}
                            : {w_rbyte[3], w_rbyte[2], w_rbyte[1], w_rbyte[0]};
    endcase
  end

  // The memory write is gated by FSM state, so an asynchronous reset during
  // ACCESS drops a pending store before it can commit.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_mem[w_base + ADDR_WIDTH'(k)] <= w_wbyte[k];
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_valid) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state <= S_ACCESS;
            r_cnt   <= 4'(WAIT_STATES);
            r_ready <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_error <= w_fault;
            r_rsp_rdata <= (w_fault || r_write) ? 32'h0
                                                : f_extend(w_load_raw, r_size, r_unsigned);
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: a main instance (one wait state)
// for functional tests plus two instances (0 and 3 wait states) for timing.
module tb_data_memory_ctrl;

  localparam int MAIN_WS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  logic        t_valid [2];
  logic        t_ready [2];
  logic        t_write [2];
  logic        t_unsigned [2];
  logic [1:0]  t_size [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata [2];
  logic        t_rsp_valid [2];
  logic        t_rsp_error [2];
  logic [31:0] t_rdata [2];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(MAIN_WS), .BIG_ENDIAN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  for (genvar g = 0; g < 2; g++) begin : g_ws
    data_memory_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(g == 0 ? 0 : 3), .BIG_ENDIAN(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(t_valid[g]), .req_ready(t_ready[g]), .req_write(t_write[g]),
      .req_size(t_size[g]), .req_unsigned(t_unsigned[g]), .req_addr(t_addr[g]),
      .req_wdata(t_wdata[g]), .rsp_valid(t_rsp_valid[g]), .rsp_rdata(t_rdata[g]),
      .rsp_error(t_rsp_error[g])
    );
  end

  // One transaction on the main instance: expectation is queued at accept
  // and compared when the response pulse appears.
  task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_wait got=%b want=1", name, req_ready);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    e.rd = exp_rd; e.err = exp_err; e.lat = MAIN_WS + 2;
    sb_q.push_back(e);
    got = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL %s rsp_timeout got=none want=rsp_valid", name);
      return;
    end
    checks++;
    if (n !== e.lat) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", name, n, e.lat);
    end
    checks++;
    if (rsp_rdata !== e.rd) begin
      failures++;
      $display("FAIL %s rdata got=%h want=%h", name, rsp_rdata, e.rd);
    end
    checks++;
    if (rsp_error !== e.err) begin
      failures++;
      $display("FAIL %s error got=%b want=%b", name, rsp_error, e.err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse got=%b want=0", name, rsp_valid);
    end
    checks++;
    if (rsp_rdata !== e.rd) begin
      failures++;
      $display("FAIL %s hold got=%h want=%h", name, rsp_rdata, e.rd);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata); end
    checks++;
    if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b want=0", rsp_error); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    issue("sw_10",  1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
    issue("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0);
  endtask

  task automatic test_subword();
    issue("lb_10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h00000011, 1'b0);
    issue("sb_11",  1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFF0, 32'h0, 1'b0);
    issue("lh_10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h000011F0, 1'b0);
  endtask

  task automatic test_extension();
    issue("lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000F0, 1'b0);
    issue("lb_11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFF0, 1'b0);
    issue("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h000011F0, 1'b0);
    issue("lw_10b", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h11F03344, 1'b0);
    issue("sh_14",  1'b1, 2'b01, 1'b0, 32'h14, 32'h12348001, 32'h0, 1'b0);
    issue("lh_14",  1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 32'hFFFF8001, 1'b0);
    issue("lhu_14", 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 32'h00008001, 1'b0);
    issue("lbu_15", 1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 32'h00000001, 1'b0);
  endtask

  task automatic test_faults();
    issue("sw_3fc",    1'b1, 2'b10, 1'b0, 32'h3FC, 32'hAABBCCDD, 32'h0, 1'b0);
    issue("lw_mis",    1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    issue("sh_mis",    1'b1, 2'b01, 1'b0, 32'h401, 32'h5555, 32'h0, 1'b1);
    issue("sw_oor",    1'b1, 2'b10, 1'b0, 32'h400, 32'h55555555, 32'h0, 1'b1);
    issue("lw_hi",     1'b0, 2'b10, 1'b0, 32'h800003FC, 32'h0, 32'h0, 1'b1);
    issue("ld_sz3",    1'b0, 2'b11, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b1);
    issue("st_sz3",    1'b1, 2'b11, 1'b0, 32'h3FC, 32'h99999999, 32'h0, 1'b1);
    issue("sw_mis",    1'b1, 2'b10, 1'b0, 32'h3FD, 32'h77777777, 32'h0, 1'b1);
    issue("sh_mis2",   1'b1, 2'b01, 1'b0, 32'h3FD, 32'h6666, 32'h0, 1'b1);
    issue("lw_3fc",    1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'hAABBCCDD, 1'b0);
  endtask

  // req_valid held high; each accept schedules its response negedge.
  task automatic test_back_to_back(input int idx, input int ws);
    int due[$];
    int accepted = 0;
    int low_run = 0;
    @(negedge clk);
    t_valid[idx] = 1'b1; t_write[idx] = 1'b1; t_size[idx] = 2'b10;
    t_unsigned[idx] = 1'b0; t_addr[idx] = 32'h0; t_wdata[idx] = 32'hA5A5_0000 + ws;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (t_rsp_valid[idx] === 1'b1) begin
        checks++;
        if (due.size() == 0 || due[0] != cyc) begin
          failures++;
          $display("FAIL b2b_ws%0d rsp_cycle got=%0d want=%0d", ws, cyc,
                   due.size() != 0 ? due[0] : -1);
        end
        if (due.size() != 0) void'(due.pop_front());
        checks++;
        if (t_rsp_error[idx] !== 1'b0 || t_rdata[idx] !== 32'h0) begin
          failures++;
          $display("FAIL b2b_ws%0d rsp_data got=%b/%h want=0/0", ws, t_rsp_error[idx], t_rdata[idx]);
        end
      end
      if (accepted == 3 && due.size() == 0) break;
      if (t_ready[idx] === 1'b1) begin
        if (accepted > 0) begin
          checks++;
          if (low_run != ws + 2) begin
            failures++;
            $display("FAIL b2b_ws%0d ready_low got=%0d want=%0d", ws, low_run, ws + 2);
          end
        end
        low_run = 0;
        if (accepted < 3) begin
          due.push_back(cyc + ws + 2);
          accepted++;
        end else begin
          t_valid[idx] = 1'b0;
        end
      end else begin
        low_run++;
      end
    end
    t_valid[idx] = 1'b0;
    checks++;
    if (accepted != 3 || due.size() != 0) begin
      failures++;
      $display("FAIL b2b_ws%0d timeout got=%0d/%0d want=3/0", ws, accepted, due.size());
    end
  endtask

  task automatic test_reset_mid_access();
    issue("sw_20_old", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    issue("lw_20_old", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL midrst_rdata got=%h want=0", rsp_rdata); end
    checks++;
    if (rsp_error !== 1'b0) begin failures++; $display("FAIL midrst_error got=%b want=0", rsp_error); end
    #3 rst_n = 1'b1;
    issue("lw_20_after", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      t_valid[i] = 1'b0; t_write[i] = 1'b0; t_size[i] = 2'b00; t_unsigned[i] = 1'b0;
      t_addr[i] = 32'h0; t_wdata[i] = 32'h0;
    end
    test_reset();
    test_word();
    test_subword();
    test_extension();
    test_faults();
    test_back_to_back(0, 0);
    test_back_to_back(1, 3);
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
